// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the five-stage MIPS pipeline.
// Chooses the next PC from sequential, jump, register-jump and taken-branch sources.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  id_pcsrc,
  input  logic [31:0] id_jr_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        id_ex_flush
);

  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_plus4_reg, pc_plus4_next;
  logic        valid_reg, valid_next;

  logic [31:0] seq_pc;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] branch_target;

  assign seq_pc        = pc_reg + 32'd4;
  assign jump_target   = {pc_plus4_reg[31:28], instr_reg[25:0], 2'b00};
  assign jr_target     = {id_jr_target[31:2], 2'b00};
  assign branch_target = {ex_branch_target[31:2], 2'b00};

  // A taken branch beats the stall: the stalled ID instruction is wrong-path anyway.
  always_comb begin
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    pc_plus4_next = pc_plus4_reg;
    valid_next    = valid_reg;
    if (ex_branch_taken) begin
      pc_next       = branch_target;
      instr_next    = 32'h0000_0000;
      pc_plus4_next = 32'h0000_0000;
      valid_next    = 1'b0;
    end else if (!stall) begin
      if (valid_reg && id_pcsrc == PCSRC_JUMP) begin
        pc_next       = jump_target;
        instr_next    = 32'h0000_0000;
        pc_plus4_next = 32'h0000_0000;
        valid_next    = 1'b0;
      end else if (valid_reg && id_pcsrc == PCSRC_JR) begin
        pc_next       = jr_target;
        instr_next    = 32'h0000_0000;
        pc_plus4_next = 32'h0000_0000;
        valid_next    = 1'b0;
      end else begin
        pc_next       = seq_pc;
        instr_next    = imem_rdata;
        pc_plus4_next = seq_pc;
        valid_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_PC;
      instr_reg    <= 32'h0000_0000;
      pc_plus4_reg <= 32'h0000_0000;
      valid_reg    <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      pc_plus4_reg <= pc_plus4_next;
      valid_reg    <= valid_next;
    end
  end

  assign imem_addr      = pc_reg;
  assign pc             = pc_reg;
  assign if_id_instr    = instr_reg;
  assign if_id_pc_plus4 = pc_plus4_reg;
  assign if_id_valid    = valid_reg;
  assign id_ex_flush    = ex_branch_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stimulus compared every cycle
// against a next-state model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall;
  logic [1:0]  id_pcsrc;
  logic [31:0] id_jr_target;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, id_ex_flush;

  // second instance for the address wrap, free-running with no redirects
  logic [31:0] w_imem_addr, w_imem_rdata, w_pc, w_instr, w_pc4;
  logic        w_valid, w_flush;
  logic        zero1 = 1'b0;
  logic [1:0]  zero2 = 2'b00;
  logic [31:0] zero32 = 32'h0;

  logic [31:0] imem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata   = imem[imem_addr[9:2]];
  assign w_imem_rdata = imem[w_imem_addr[9:2]];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .id_pcsrc(id_pcsrc), .id_jr_target(id_jr_target),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .id_ex_flush(id_ex_flush)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .stall(zero1), .id_pcsrc(zero2), .id_jr_target(zero32),
    .ex_branch_taken(zero1), .ex_branch_target(zero32),
    .pc(w_pc), .if_id_instr(w_instr), .if_id_pc_plus4(w_pc4),
    .if_id_valid(w_valid), .id_ex_flush(w_flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } st_t;

  function automatic st_t model_next(input st_t s, input logic rst, input logic stl,
                                     input logic [1:0] src, input logic [31:0] jr,
                                     input logic bt, input logic [31:0] btgt,
                                     input logic [31:0] fetched);
    st_t bubble_to;
    bubble_to = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0};
    if (rst) begin
      bubble_to.pc = 32'h0;
      return bubble_to;
    end
    if (bt) begin
      bubble_to.pc = btgt & ~32'd3;
      return bubble_to;
    end
    if (stl) return s;
    if (s.valid && src == 2'd1) begin
      bubble_to.pc = (s.pc4 & 32'hF000_0000) | ((s.instr & 32'h03FF_FFFF) * 4);
      return bubble_to;
    end
    if (s.valid && src == 2'd2) begin
      bubble_to.pc = jr & ~32'd3;
      return bubble_to;
    end
    return '{pc: s.pc + 4, instr: fetched, pc4: s.pc + 4, valid: 1'b1};
  endfunction

  st_t m;
  logic m_init = 1'b0;

  always @(posedge clk) begin
    m <= model_next(m, reset, stall, id_pcsrc, id_jr_target, ex_branch_taken,
                    ex_branch_target, imem[m.pc[9:2]]);
    if (reset) m_init <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("pc", pc, m.pc);
      chk("imem_addr", imem_addr, m.pc);
      chk("if_id_instr", if_id_instr, m.instr);
      chk("if_id_pc_plus4", if_id_pc_plus4, m.pc4);
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m.valid});
      chk("id_ex_flush", {31'b0, id_ex_flush}, {31'b0, ex_branch_taken});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic stl, input logic [1:0] src,
                       input logic [31:0] jr, input logic bt, input logic [31:0] btgt);
    reset = rst; stall = stl; id_pcsrc = src; id_jr_target = jr;
    ex_branch_taken = bt; ex_branch_target = btgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0]   = 32'h2008_0005;
    imem[1]   = 32'h2009_0003;
    imem[2]   = 32'h0800_0010;
    imem[3]   = 32'h200A_0007;
    imem[16]  = 32'h2010_0001;
    imem[72]  = 32'h2011_0002;   // address 0x120
    imem[128] = 32'h2012_0003;   // address 0x200
    imem[255] = 32'h1234_5678;   // address 0x3FC / 0xFFFF_FFFC

    reset = 1'b1; stall = 1'b0; id_pcsrc = 2'b00; id_jr_target = 32'h0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
    #1;

    // reset
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);

    // free run
    drive(0, 0, 0, 0, 0, 0);
    chk("run_pc4", pc, 32'h4);
    chk("run_instr0", if_id_instr, 32'h2008_0005);
    chk("run_pcplus4", if_id_pc_plus4, 32'h4);
    chk("run_valid", {31'b0, if_id_valid}, 32'h1);
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_pcplus4", w_pc4, 32'h0);
    chk("wrap_instr", w_instr, 32'h1234_5678);
    drive(0, 0, 0, 0, 0, 0);
    chk("run_pc8", pc, 32'h8);
    drive(0, 0, 0, 0, 0, 0);
    chk("j_in_id", if_id_instr, 32'h0800_0010);

    // jump
    drive(0, 0, 2'b01, 0, 0, 0);
    chk("j_pc", pc, 32'h40);
    chk("j_bubble", {31'b0, if_id_valid}, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    chk("j_target_in_id", if_id_instr, 32'h2010_0001);
    chk("j_target_pc4", if_id_pc_plus4, 32'h44);

    // stalled jr, then redirect
    drive(0, 1, 2'b10, 32'h123, 0, 0);
    drive(0, 1, 2'b10, 32'h123, 0, 0);
    chk("stall_pc", pc, 32'h44);
    chk("stall_instr", if_id_instr, 32'h2010_0001);
    drive(0, 0, 2'b10, 32'h123, 0, 0);
    chk("jr_pc", pc, 32'h120);
    chk("jr_bubble", {31'b0, if_id_valid}, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    chk("jr_target_in_id", if_id_instr, 32'h2011_0002);

    // taken branch beats stall and jump
    drive(0, 1, 2'b01, 0, 1, 32'h203);
    chk("br_flush", {31'b0, id_ex_flush}, 32'h1);
    chk("br_pc", pc, 32'h200);
    chk("br_bubble", {31'b0, if_id_valid}, 32'h0);
    // bubble in ID never redirects
    drive(0, 0, 2'b01, 0, 0, 0);
    chk("bubble_no_jump", pc, 32'h204);
    chk("br_target_in_id", if_id_instr, 32'h2012_0003);

    // reset with stall and a jump in ID
    drive(1, 1, 2'b01, 0, 0, 0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_bubble", {31'b0, if_id_valid}, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    chk("midrst_fetch", if_id_instr, 32'h2008_0005);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            $urandom,
            ($urandom_range(0, 7) == 0),
            32'($urandom_range(0, 1023)));
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. Holds the PC and drives the instruction-memory address. Selects the next PC from sequential, jump (j/jal), register-jump (jr/jalr) and taken-branch (beq) sources. Presents the fetched instruction and PC+4 to the ID stage, where the control decoder consumes the instruction's opcode/funct and returns its PCSrc decision here.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  instruction-memory address; combinationally equal to pc
- imem_rdata  in  32  instruction word at imem_addr; combinational memory, valid same cycle
- stall  in  1  load-use hazard from hazard unit: hold PC and IF/ID
- id_pcsrc  in  2  decoder PCSrc for the instruction in ID: 00 sequential, 01 j/jal, 10 jr/jalr, 11 treated as 00
- id_jr_target  in  32  forwarded rs value for jr/jalr
- ex_branch_taken  in  1  beq in EX resolved taken
- ex_branch_target  in  32  branch target computed in EX
- pc  out  32  current fetch PC
- if_id_instr  out  32  instruction in ID
- if_id_pc_plus4  out  32  PC+4 of instruction in ID
- if_id_valid  out  1  1 = if_id_instr is a real instruction, 0 = bubble
- id_ex_flush  out  1  combinational; 1 when ID/EX must load a bubble next edge (equals ex_branch_taken)

## Operation
- Bubble: if_id_instr = 32'h0000_0000 (sll $0,$0,0; decoded as nop, no write), if_id_pc_plus4 = 0, if_id_valid = 0.
- Jump target is built internally: {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
- jr target: {id_jr_target[31:2], 2'b00}; low two bits forced to zero.
- Sequential increment: pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- No delay slot: any redirect squashes the instruction fetched in the same cycle.
- Per-edge update, highest priority first:
  - reset: pc <= RESET_PC; IF/ID <= bubble.
  - ex_branch_taken: pc <= {ex_branch_target[31:2], 2'b00}; IF/ID <= bubble. Overrides stall and id_pcsrc, because the ID instruction is wrong-path. id_ex_flush = 1 squashes it in ID/EX.
  - stall: pc and IF/ID hold. id_pcsrc is ignored, so a stalled jr re-evaluates next cycle with the forwarded operand.
  - id_pcsrc = 01: pc <= jump target; IF/ID <= bubble.
  - id_pcsrc = 10: pc <= jr target; IF/ID <= bubble.
  - otherwise: pc <= pc + 4; if_id_instr <= imem_rdata; if_id_pc_plus4 <= pc + 4; if_id_valid <= 1.
- id_pcsrc is only honoured when if_id_valid = 1; a bubble in ID never redirects.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, if_id_instr = 0, if_id_pc_plus4 = 0, if_id_valid = 0, id_ex_flush follows ex_branch_taken.
- Instruction at address A appears on if_id_* one edge after pc = A, with no stall or redirect.
- Jump and jr penalty: 1 bubble. Target is fetched the cycle after the jump is in ID.
- Taken-branch penalty: 2 bubbles (IF/ID here plus ID/EX via id_ex_flush). Target is fetched the cycle after the branch is in EX.
- Reset asserted mid-stream overrides everything on that edge. The first fetch after deassertion is at RESET_PC.
- stall held N cycles: pc and IF/ID are stable for exactly N edges. Sequential flow resumes on the first edge with stall = 0.
- Outputs pc, if_id_* are registered. imem_addr and id_ex_flush are combinational.

## Test plan
- Reset then free-run, imem[0]=32'h2008_0005, imem[4]=32'h2009_0003: pc sequence 0,4,8; if_id_instr = 32'h2008_0005 with if_id_pc_plus4 = 4 and valid = 1 one edge after pc = 0.
- j at address 8 (instr 32'h0800_0010) with id_pcsrc = 01 while it is in ID: next pc = 32'h0000_0040; the instruction from 12 becomes a bubble (valid = 0); the instruction at 0x40 reaches ID two edges after the jump entered ID.
- jr with id_jr_target = 32'h0000_0123, id_pcsrc = 10: pc = 32'h0000_0120 and one bubble; repeat with stall = 1 for 2 cycles first, giving pc and if_id_instr frozen 2 edges, then the redirect.
- ex_branch_taken = 1, target 32'h0000_0200, with stall = 1 and id_pcsrc = 01 the same cycle: pc = 0x200, IF/ID bubble, id_ex_flush = 1; the stall and the jump are both ignored.
- Wrap: RESET_PC = 32'hFFFF_FFFC, no redirects: pc goes FFFF_FFFC then 0000_0000; if_id_pc_plus4 = 0 for the instruction at FFFF_FFFC.
- Reset asserted while stall = 1 and a jump is in ID: pc = RESET_PC and IF/ID bubble on that edge; normal fetch from RESET_PC after deassertion.
